// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, flag bit positions and FSM states for the
// sequential ALU and its iterative multiplier.
package alu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_NOT = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_ADC = 4'h8;
   localparam logic [3:0] OP_SBC = 4'h9;
   localparam logic [3:0] OP_MUL = 4'hA;
   localparam logic [3:0] OP_CMP = 4'hB;

   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } aluState_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per clock.
// The multiplier operand sits in the low half of the accumulator and is shifted
// out as the running sum shifts in from the top. done_o is asserted during the
// final step, with product_o already showing the completed product so the
// parent can capture it on that same edge.
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rstN_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]      count_q;
   logic               busy_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     partSum;
   logic [2*WIDTH-1:0] accNext;

   // One shift-add step: conditionally add the multiplicand to the upper half,
   // then shift the whole accumulator (with the carry) right by one.
   always_comb begin
      addend  = acc_q[0] ? mcand_q : '0;
      partSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      accNext = {partSum, acc_q[WIDTH-1:1]};
   end

   assign busy_o    = busy_q;
   assign done_o    = busy_q & (count_q == CW'(1));
   assign product_o = accNext;

   // Load operands on start, step while busy and stop after WIDTH steps; an abort
   // simply drops the in-flight product.
   always_ff @(posedge clk_i or negedge rstN_i) begin
      if (!rstN_i) begin
         busy_q  <= 1'b0;
         count_q <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
      end else if (abort_i) begin
         busy_q  <= 1'b0;
         count_q <= '0;
      end else if (start_i) begin
         busy_q  <= 1'b1;
         count_q <= CW'(WIDTH);
         mcand_q <= a_i;
         acc_q   <= {{WIDTH{1'b0}}, b_i};
      end else if (busy_q) begin
         acc_q   <= accNext;
         count_q <= count_q - CW'(1);
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with valid/ready handshakes on both sides
// and an internal {V,C,N,Z} flag register feeding ADC/SBC.
// Build option ALU_MUL_EN: when defined, opcode MUL runs on the iterative
// multiplier (WIDTH+1 cycle latency, unit busy meanwhile); when undefined, MUL
// decodes as an illegal opcode and no multiplier is generated.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_data_1,
   input  logic [WIDTH-1:0] i_data_2,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_result_hi,
   output logic [3:0]       o_flags,
   output logic             o_illegal
);

   localparam int SHW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   aluState_e          state_q, state_d;
   logic [WIDTH-1:0]   resLo_q, resLo_d;
   logic [WIDTH-1:0]   resHi_q, resHi_d;
   logic [3:0]         flags_q, flags_d;
   logic               valid_q, valid_d;
   logic               illegal_q, illegal_d;

   logic               ready;
   logic               accept;
   logic               isMul;
   logic               mulStart;
   logic               mulBusy;
   logic               mulDone;
   logic               mulCommit;
   logic [2*WIDTH-1:0] mulProd;

   logic [WIDTH-1:0]   aluRes;
   logic [WIDTH-1:0]   znVal;
   logic [3:0]         aluFlags;
   logic               aluIllegal;
   logic               updZn;
   logic               bigShift;
   logic [SHW-1:0]     shAmt;
   logic [WIDTH:0]     addSum;
   logic [WIDTH:0]     subDiff;
   logic [WIDTH:0]     shlVal;
   logic [WIDTH:0]     shrVal;

   assign ready  = (state_q == ST_IDLE) & (~valid_q | i_ready) & ~i_flush;
   assign accept = i_valid & ready;

`ifdef ALU_MUL_EN
   assign isMul    = (i_op == OP_MUL);
   assign mulStart = accept & isMul;

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk_i    (i_clk),
      .rstN_i   (i_rst_n),
      .start_i  (mulStart),
      .abort_i  (i_flush),
      .a_i      (i_data_1),
      .b_i      (i_data_2),
      .busy_o   (mulBusy),
      .done_o   (mulDone),
      .product_o(mulProd)
   );
`else
   assign isMul    = 1'b0;
   assign mulStart = 1'b0;
   assign mulBusy  = 1'b0;
   assign mulDone  = 1'b0;
   assign mulProd  = '0;
`endif

   assign mulCommit = (state_q == ST_MUL_RUN) & mulBusy & mulDone;

   // Single-cycle datapath: one shared adder/subtractor with the registered carry
   // folded in for ADC/SBC, shifts done one bit wider so the bit shifted out
   // lands in the extra position and becomes C.
   always_comb begin
      shAmt    = i_data_2[SHW-1:0];
      bigShift = (i_data_2 > WIDTH_V);
      addSum   = {1'b0, i_data_1} + {1'b0, i_data_2}
               + {{WIDTH{1'b0}}, flags_q[FLG_C] & (i_op == OP_ADC)};
      subDiff  = {1'b0, i_data_1} - {1'b0, i_data_2}
               - {{WIDTH{1'b0}}, flags_q[FLG_C] & (i_op == OP_SBC)};
      shlVal   = {1'b0, i_data_1} << shAmt;
      shrVal   = {i_data_1, 1'b0} >> shAmt;

      aluRes     = '0;
      aluFlags   = flags_q;
      aluIllegal = 1'b0;
      updZn      = 1'b1;

      case (i_op)
         OP_NOP: begin
            aluRes = i_data_1;
            updZn  = 1'b0;
         end
         OP_NOT: aluRes = ~i_data_1;
         OP_ADD, OP_ADC: begin
            aluRes          = addSum[WIDTH-1:0];
            aluFlags[FLG_C] = addSum[WIDTH];
            aluFlags[FLG_V] = (i_data_1[WIDTH-1] == i_data_2[WIDTH-1])
                            & (addSum[WIDTH-1] != i_data_1[WIDTH-1]);
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            aluRes          = (i_op == OP_CMP) ? i_data_1 : subDiff[WIDTH-1:0];
            aluFlags[FLG_C] = subDiff[WIDTH];
            aluFlags[FLG_V] = (i_data_1[WIDTH-1] != i_data_2[WIDTH-1])
                            & (subDiff[WIDTH-1] != i_data_1[WIDTH-1]);
         end
         OP_AND: aluRes = i_data_1 & i_data_2;
         OP_OR:  aluRes = i_data_1 | i_data_2;
         OP_SHL: begin
            aluRes          = bigShift ? '0 : shlVal[WIDTH-1:0];
            aluFlags[FLG_C] = bigShift ? 1'b0 : shlVal[WIDTH];
         end
         OP_SHR: begin
            aluRes          = bigShift ? '0 : shrVal[WIDTH:1];
            aluFlags[FLG_C] = bigShift ? 1'b0 : shrVal[0];
         end
`ifdef ALU_MUL_EN
         OP_MUL: updZn = 1'b0;
`endif
         default: begin
            aluIllegal = 1'b1;
            updZn      = 1'b0;
         end
      endcase

      znVal = (i_op == OP_CMP) ? subDiff[WIDTH-1:0] : aluRes;
      if (updZn) begin
         aluFlags[FLG_Z] = (znVal == '0);
         aluFlags[FLG_N] = znVal[WIDTH-1];
      end
   end

   // Control FSM: park in MUL_RUN while the multiplier iterates; flush or the
   // final multiplier step returns to IDLE.
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (mulStart) state_d = ST_MUL_RUN;
            ST_MUL_RUN: if (mulDone)  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Output entry and flag register: flush drops the entry without touching
   // flags, otherwise a new single-cycle result or a finished product replaces
   // the entry, and a consumed entry is retired.
   always_comb begin
      valid_d   = valid_q;
      resLo_d   = resLo_q;
      resHi_d   = resHi_q;
      flags_d   = flags_q;
      illegal_d = illegal_q;
      if (i_flush) begin
         valid_d = 1'b0;
      end else if (accept & ~isMul) begin
         valid_d   = 1'b1;
         resLo_d   = aluRes;
         resHi_d   = '0;
         flags_d   = aluFlags;
         illegal_d = aluIllegal;
      end else if (mulCommit) begin
         valid_d          = 1'b1;
         resLo_d          = mulProd[WIDTH-1:0];
         resHi_d          = mulProd[2*WIDTH-1:WIDTH];
         illegal_d        = 1'b0;
         flags_d[FLG_Z]   = (mulProd == '0);
         flags_d[FLG_N]   = mulProd[2*WIDTH-1];
         flags_d[FLG_C]   = (mulProd[2*WIDTH-1:WIDTH] != '0);
         flags_d[FLG_V]   = (mulProd[2*WIDTH-1:WIDTH] != '0);
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers; reset also abandons any multiply in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         resLo_q   <= '0;
         resHi_q   <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         resLo_q   <= resLo_d;
         resHi_q   <= resHi_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
      end
   end

   assign o_ready     = ready;
   assign o_valid     = valid_q;
   assign o_result    = resLo_q;
   assign o_result_hi = resHi_q;
   assign o_flags     = flags_q;
   assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against an arithmetic reference model of alu_seq.
// Build with +define+ALU_MUL_EN to exercise the multiplier variant.
module tb_alu_seq;

   localparam int W = 16;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN  = 1'b1;
`else
   localparam bit MUL_EN  = 1'b0;
`endif
   localparam int MUL_LAT = W + 1;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         flush = 1'b0;
   logic         inValid = 1'b0;
   logic         inReady = 1'b1;
   logic [3:0]   op = '0;
   logic [W-1:0] dataA = '0;
   logic [W-1:0] dataB = '0;
   logic         outReady;
   logic         outValid;
   logic [W-1:0] result;
   logic [W-1:0] resultHi;
   logic [3:0]   flags;
   logic         illegal;

   int           nCompared = 0;
   int           nMismatched = 0;
   logic [3:0]   curFlags = '0;

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] hi;
      logic [3:0]  flags;
      logic        illegal;
   } expT;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] hi;
      logic [3:0]  flags;
      logic        illegal;
   } vecT;

   vecT vecs[$];

   alu_seq #(.WIDTH(W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_flush    (flush),
      .i_valid    (inValid),
      .o_ready    (outReady),
      .i_op       (op),
      .i_data_1   (dataA),
      .i_data_2   (dataB),
      .o_valid    (outValid),
      .i_ready    (inReady),
      .o_result   (result),
      .o_result_hi(resultHi),
      .o_flags    (flags),
      .o_illegal  (illegal)
   );

   always #5 clk = ~clk;

   // Reference model: integer arithmetic straight from the opcode definitions.
   function automatic expT model(input logic [3:0] mop, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] fin);
      expT     e;
      int      ua, ub, sa, sb, cin, r, sr;
      longint  p;
      logic    c, v;
      bit      setZn, ill;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      cin = fin[2] ? 1 : 0;
      c = fin[2];
      v = fin[3];
      setZn = 1'b1;
      ill = 1'b0;
      r = 0;
      sr = 0;
      p = 0;
      e.hi = '0;
      e.illegal = 1'b0;
      e.flags = fin;
      case (mop)
         4'h0: begin r = ua; setZn = 1'b0; end
         4'h1: r = ~ua;
         4'h2: begin r = ua + ub; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
         4'h3: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
         4'h4: r = ua & ub;
         4'h5: r = ua | ub;
         4'h6: begin
            if (ub == 0) begin r = ua; c = 1'b0; end
            else if (ub > 16) begin r = 0; c = 1'b0; end
            else begin r = ua << ub; c = ((ua >> (16 - ub)) & 1) == 1; end
         end
         4'h7: begin
            if (ub == 0) begin r = ua; c = 1'b0; end
            else if (ub > 16) begin r = 0; c = 1'b0; end
            else begin r = ua >> ub; c = ((ua >> (ub - 1)) & 1) == 1; end
         end
         4'h8: begin r = ua + ub + cin; c = (r > 65535); sr = sa + sb + cin; v = (sr > 32767) || (sr < -32768); end
         4'h9: begin r = ua - ub - cin; c = (ua < ub + cin); sr = sa - sb - cin; v = (sr > 32767) || (sr < -32768); end
         4'hA: begin
            if (MUL_EN) begin
               p = longint'(ua) * longint'(ub);
               e.res = p[15:0];
               e.hi = p[31:16];
               e.flags = {(p[31:16] != 0), (p[31:16] != 0), p[31], (p == 0)};
               return e;
            end
            ill = 1'b1;
         end
         4'hB: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         e.res = '0;
         e.illegal = 1'b1;
         return e;
      end
      e.res = (mop == 4'hB) ? a : r[15:0];
      e.flags = {v, c, setZn ? r[15] : fin[1], setZn ? (r[15:0] == 0) : fin[0]};
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one op, wait (bounded) for acceptance and then for its entry.
   task automatic applyStimulus(input logic [3:0] sop, input logic [15:0] a,
                                input logic [15:0] b, output int lat);
      int waitCnt;
      waitCnt = 0;
      op = sop;
      dataA = a;
      dataB = b;
      inValid = 1'b1;
      while (!outReady && waitCnt < 100) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!outReady) begin
         inValid = 1'b0;
         checkOutput("accept timeout", 32'd0, 32'd1);
         lat = -1;
         return;
      end
      @(posedge clk); #1;
      inValid = 1'b0;
      lat = 1;
      while (!outValid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic checkEntry(input string name, input expT e, input logic [3:0] eop, input int lat);
      int expLat;
      expLat = (eop == 4'hA && MUL_EN) ? MUL_LAT : 1;
      checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, " result"}, {16'h0, result}, {16'h0, e.res});
      checkOutput({name, " result_hi"}, {16'h0, resultHi}, {16'h0, e.hi});
      checkOutput({name, " flags"}, {28'h0, flags}, {28'h0, e.flags});
      checkOutput({name, " illegal"}, {31'h0, illegal}, {31'h0, e.illegal});
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   lat;
      int   cnt;
      expT  e;
      logic [3:0]  rop;
      logic [15:0] ra, rb;

      // {V,C,N,Z} expectations derived by hand, starting from flags = 0.
      vecs.push_back('{4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 4'h5, 1'b0});
      vecs.push_back('{4'h8, 16'h0000, 16'h0000, 16'h0001, 16'h0, 4'h0, 1'b0});
      vecs.push_back('{4'h3, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0, 4'hE, 1'b0});
      vecs.push_back('{4'hB, 16'h0005, 16'h0005, 16'h0005, 16'h0, 4'h1, 1'b0});
      vecs.push_back('{4'h6, 16'h8888, 16'h0005, 16'h1100, 16'h0, 4'h4, 1'b0});
      vecs.push_back('{4'h7, 16'h0001, 16'h0001, 16'h0000, 16'h0, 4'h5, 1'b0});
      vecs.push_back('{4'h6, 16'h1234, 16'h0011, 16'h0000, 16'h0, 4'h1, 1'b0});
      vecs.push_back('{4'h1, 16'h00FF, 16'h0000, 16'hFF00, 16'h0, 4'h2, 1'b0});
      vecs.push_back('{4'h0, 16'h1234, 16'h5678, 16'h1234, 16'h0, 4'h2, 1'b0});
      vecs.push_back('{4'hC, 16'h1234, 16'h5678, 16'h0000, 16'h0, 4'h2, 1'b1});
      vecs.push_back('{4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'h0, 4'h6, 1'b0});
      vecs.push_back('{4'h9, 16'h0005, 16'h0002, 16'h0002, 16'h0, 4'h0, 1'b0});
      vecs.push_back('{4'h2, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 4'hA, 1'b0});
      vecs.push_back('{4'h7, 16'h8000, 16'h0010, 16'h0000, 16'h0, 4'hD, 1'b0});
      vecs.push_back('{4'h4, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0, 4'hC, 1'b0});
      vecs.push_back('{4'h5, 16'h0000, 16'h0000, 16'h0000, 16'h0, 4'hD, 1'b0});
`ifdef ALU_MUL_EN
      vecs.push_back('{4'hA, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'hE, 1'b0});
`else
      vecs.push_back('{4'hA, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'hD, 1'b1});
`endif

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset valid", {31'h0, outValid}, 32'd0);
      checkOutput("reset result", {16'h0, result}, 32'd0);
      checkOutput("reset result_hi", {16'h0, resultHi}, 32'd0);
      checkOutput("reset flags", {28'h0, flags}, 32'd0);
      checkOutput("reset illegal", {31'h0, illegal}, 32'd0);
      rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset ready", {31'h0, outReady}, 32'd1);

      // Directed table.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         e = '{res: vecs[i].res, hi: vecs[i].hi, flags: vecs[i].flags, illegal: vecs[i].illegal};
         checkEntry($sformatf("vec%0d", i), e, vecs[i].op, lat);
      end
      curFlags = vecs[vecs.size() - 1].flags;

      // Back-to-back ADD then ADC: the ADC must see the carry from the ADD.
      @(posedge clk); #1;
      checkOutput("b2b ready", {31'h0, outReady}, 32'd1);
      op = 4'h2; dataA = 16'hFFFF; dataB = 16'h0001; inValid = 1'b1;
      @(posedge clk); #1;
      checkOutput("b2b add valid", {31'h0, outValid}, 32'd1);
      checkOutput("b2b add result", {16'h0, result}, 32'h0000);
      checkOutput("b2b add flags", {28'h0, flags}, 32'h5);
      checkOutput("b2b add ready", {31'h0, outReady}, 32'd1);
      op = 4'h8; dataA = 16'h0000; dataB = 16'h0000;
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput("b2b adc valid", {31'h0, outValid}, 32'd1);
      checkOutput("b2b adc result", {16'h0, result}, 32'h0001);
      checkOutput("b2b adc flags", {28'h0, flags}, 32'h0);

      // Backpressure: entry must hold and the unit must refuse new work.
      @(posedge clk); #1;
      inReady = 1'b0;
      applyStimulus(4'h2, 16'h8000, 16'h8000, lat);
      checkEntry("bp add", model(4'h2, 16'h8000, 16'h8000, 4'h0), 4'h2, lat);
      op = 4'h3; dataA = 16'h0001; dataB = 16'h0002; inValid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("bp ready c%0d", k), {31'h0, outReady}, 32'd0);
         checkOutput($sformatf("bp valid c%0d", k), {31'h0, outValid}, 32'd1);
         checkOutput($sformatf("bp result c%0d", k), {16'h0, result}, 32'h0000);
         checkOutput($sformatf("bp flags c%0d", k), {28'h0, flags}, 32'hD);
      end

      // Flush while downstream frees up and an op is presented: flush wins.
      inReady = 1'b1;
      flush = 1'b1;
      #1;
      checkOutput("flush ready", {31'h0, outReady}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      inValid = 1'b0;
      checkOutput("flush valid", {31'h0, outValid}, 32'd0);
      checkOutput("flush flags", {28'h0, flags}, 32'hD);
      @(posedge clk); #1;
      checkOutput("flush op dropped", {31'h0, outValid}, 32'd0);
      curFlags = 4'hD;

`ifdef ALU_MUL_EN
      // MUL timing: busy for WIDTH cycles, entry in cycle WIDTH+1.
      op = 4'hA; dataA = 16'hFFFF; dataB = 16'hFFFF; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      cnt = 0;
      for (int k = 0; k < 40 && !outValid; k++) begin
         if (!outReady) cnt++;
         @(posedge clk); #1;
      end
      checkOutput("mul busy cycles", 32'(cnt), 32'd16);
      checkOutput("mul valid", {31'h0, outValid}, 32'd1);
      checkOutput("mul lo", {16'h0, result}, 32'h0001);
      checkOutput("mul hi", {16'h0, resultHi}, 32'hFFFE);
      checkOutput("mul flags", {28'h0, flags}, 32'hE);

      // Flush mid-MUL: no entry ever appears, flags untouched.
      @(posedge clk); #1;
      op = 4'hA; dataA = 16'h0003; dataB = 16'h0005; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("mul flush ready", {31'h0, outReady}, 32'd1);
      cnt = 0;
      repeat (20) begin
         if (outValid) cnt++;
         @(posedge clk); #1;
      end
      checkOutput("mul flush no entry", 32'(cnt), 32'd0);
      checkOutput("mul flush flags", {28'h0, flags}, 32'hE);
`endif

      // Reset while a MUL is in flight.
      op = 4'hA; dataA = 16'h00FF; dataB = 16'h0101; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rstN = 1'b0;
      #1;
      checkOutput("rst mid valid", {31'h0, outValid}, 32'd0);
      checkOutput("rst mid flags", {28'h0, flags}, 32'd0);
      checkOutput("rst mid result", {16'h0, result}, 32'd0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst mid ready", {31'h0, outReady}, 32'd1);
      cnt = 0;
      repeat (20) begin
         if (outValid) cnt++;
         @(posedge clk); #1;
      end
      checkOutput("rst mid no entry", 32'(cnt), 32'd0);
      curFlags = 4'h0;

      // Randomized ops against the reference model.
      for (int n = 0; n < 150; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 3) == 0) ra = (($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF);
         if ($urandom_range(0, 5) == 0) rb = 16'hFFFF;
         if (rop == 4'h6 || rop == 4'h7) rb = 16'($urandom_range(0, 20));
         e = model(rop, ra, rb, curFlags);
         applyStimulus(rop, ra, rb, lat);
         checkEntry($sformatf("rnd%0d op%0h", n, rop), e, rop, lat);
         curFlags = e.flags;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
